// File: rtl/ps2_frame_rx_pkg.sv
// Shared types, constants and parameter-derived cycle counts for the PS/2 receiver.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int unsigned FRAME_DATA_BITS = 8;

  // Deglitch window in clocks; never shorter than two clocks.
  function automatic int unsigned filter_cycles(int unsigned clk_freq, int unsigned filter_ns);
    longint unsigned c;
    c = 64'(clk_freq) * 64'(filter_ns) / 64'd1_000_000_000;
    if (c < 64'd2) return 2;
    return 32'(c);
  endfunction

  // Maximum gap between falling edges inside a frame, in clocks.
  function automatic int unsigned timeout_cycles(int unsigned clk_freq, int unsigned timeout_us);
    return 32'(64'(clk_freq) / 64'd1_000_000 * 64'(timeout_us));
  endfunction

  // Clock-low hold after a rejected frame, in clocks.
  function automatic int unsigned inhibit_cycles(int unsigned clk_freq, int unsigned inhibit_us);
    return 32'(64'(clk_freq) / 64'd1_000_000 * 64'(inhibit_us));
  endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// PS/2 pin and received-byte bundle. master = receiver side, slave = pins/consumer side.
interface ps2_frame_rx_if;
  import ps2_rx_pkg::*;

  logic                       ps2_clk_in;
  logic                       ps2_dat_in;
  logic                       ps2_clk_out;
  logic                       ps2_dat_out;
  logic [FRAME_DATA_BITS-1:0] dataout;
  logic                       dataout_valid;
  logic                       dataout_error;

  modport master (
    input  ps2_clk_in, ps2_dat_in,
    output ps2_clk_out, ps2_dat_out, dataout, dataout_valid, dataout_error
  );

  modport slave (
    output ps2_clk_in, ps2_dat_in,
    input  ps2_clk_out, ps2_dat_out, dataout, dataout_valid, dataout_error
  );

endinterface

// File: rtl/ps2_frame_rx_line_filter.sv
// 2-FF synchroniser followed by a deglitch counter; output resets to 1 (idle line).
module ps2_line_filter #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CW = $clog2(CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Accept a new level only after CYCLES consecutive clocks of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      filt  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: filtered lines, 11-bit frame deserialiser,
// odd-parity/stop check and inter-edge timeout.
// Optional clock inhibit after errors: define PS2_RX_INHIBIT_EN.
module ps2_frame_rx
  import ps2_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 28_000_000,
  parameter int unsigned FILTER_NS  = 1000,
  parameter int unsigned TIMEOUT_US = 1000
`ifdef PS2_RX_INHIBIT_EN
  ,
  parameter int unsigned INHIBIT_US = 100
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  ps2_frame_rx_if.master bus
);

  localparam int unsigned FILTER_CYCLES  = filter_cycles(CLK_FREQ, FILTER_NS);
  localparam int unsigned TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ, TIMEOUT_US);
  localparam int unsigned TCW            = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BCW            = $clog2(FRAME_DATA_BITS);

  logic                       clk_f;
  logic                       dat_f;
  logic                       clk_q;
  logic                       fall;
  logic                       fall_dat;
  logic                       inhibit;

  state_t                     state;
  logic [BCW-1:0]             bit_cnt;
  logic [FRAME_DATA_BITS-1:0] shreg;
  logic                       par_bit;
  logic [TCW-1:0]             to_cnt;
  logic [FRAME_DATA_BITS-1:0] data_q;
  logic                       valid_q;
  logic                       error_q;

  ps2_line_filter #(.CYCLES(FILTER_CYCLES)) u_clk_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.ps2_clk_in),
    .filt  (clk_f)
  );

  ps2_line_filter #(.CYCLES(FILTER_CYCLES)) u_dat_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.ps2_dat_in),
    .filt  (dat_f)
  );

  // Register the filtered-clock falling edge together with the data level seen with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_q    <= 1'b1;
      fall     <= 1'b0;
      fall_dat <= 1'b1;
    end else begin
      clk_q    <= clk_f;
      fall     <= clk_q & ~clk_f;
      fall_dat <= dat_f;
    end
  end

  // Frame FSM: deserialise, check, strobe; a falling edge wins over a same-cycle timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (fall && !inhibit && !fall_dat) begin
            state   <= DATA;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        default: begin
          if (fall) begin
            to_cnt <= '0;
            case (state)
              DATA: begin
                shreg[bit_cnt] <= fall_dat;
                if (bit_cnt == BCW'(FRAME_DATA_BITS - 1)) state <= PARITY;
                else bit_cnt <= bit_cnt + BCW'(1);
              end
              PARITY: begin
                par_bit <= fall_dat;
                state   <= STOP;
              end
              default: begin
                if ((^{shreg, par_bit}) && fall_dat) begin
                  data_q  <= shreg;
                  valid_q <= 1'b1;
                end else begin
                  error_q <= 1'b1;
                end
                state <= IDLE;
              end
            endcase
          end else if (to_cnt >= TCW'(TIMEOUT_CYCLES - 1)) begin
            error_q <= 1'b1;
            state   <= IDLE;
            to_cnt  <= '0;
            shreg   <= '0;
          end else begin
            to_cnt <= to_cnt + TCW'(1);
          end
        end
      endcase
    end
  end

  assign bus.dataout       = data_q;
  assign bus.dataout_valid = valid_q;
  assign bus.dataout_error = error_q;
  assign bus.ps2_dat_out   = 1'b1;

`ifdef PS2_RX_INHIBIT_EN
  localparam int unsigned INHIBIT_CYCLES = inhibit_cycles(CLK_FREQ, INHIBIT_US);
  localparam int unsigned HOLD_CYCLES    = INHIBIT_CYCLES + FILTER_CYCLES;
  localparam int unsigned ICW            = $clog2(HOLD_CYCLES + 1);

  logic [ICW-1:0] inh_cnt;
  logic           clk_drv;

  // One counter covers the clock-low hold and the filter settle time after release;
  // the line is released when only FILTER_CYCLES remain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inh_cnt <= '0;
      clk_drv <= 1'b1;
    end else if (error_q) begin
      inh_cnt <= ICW'(HOLD_CYCLES);
      clk_drv <= 1'b0;
    end else if (inh_cnt != '0) begin
      inh_cnt <= inh_cnt - ICW'(1);
      if (inh_cnt == ICW'(FILTER_CYCLES + 1)) clk_drv <= 1'b1;
    end
  end

  assign inhibit         = (inh_cnt != '0);
  assign bus.ps2_clk_out = clk_drv;
`else
  assign inhibit         = 1'b0;
  assign bus.ps2_clk_out = 1'b1;
`endif

endmodule

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
- PS/2 device-to-host serial receiver: line synchroniser, deglitch filter, frame deserialiser, parity/stop check, inactivity timeout.
- Sits directly upstream of the keyboard scancode decoder.
- Delivers one byte per valid 11-bit frame as a single-cycle strobe, or a single-cycle error strobe.
- Drives the open-drain PS/2 outputs; these stay released unless the optional inhibit feature is compiled in.

Parameters:
- CLK_FREQ, 28_000_000, system clock frequency in Hz.
- FILTER_NS, 1000, minimum stable time in ns for a line level to be accepted.
- TIMEOUT_US, 1000, maximum gap in µs between falling edges inside a frame.
- INHIBIT_US, 100, clock-low hold time in µs after an error (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ps2_clk_in  in  1  raw PS/2 clock pin level
- ps2_dat_in  in  1  raw PS/2 data pin level
- ps2_clk_out  out  1  open-drain clock drive; 1 = released
- ps2_dat_out  out  1  open-drain data drive; 1 = released
- dataout  out  8  last correctly received byte
- dataout_valid  out  1  one-cycle strobe: dataout updated
- dataout_error  out  1  one-cycle strobe: frame rejected

Behaviour:
- Reset and clock: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: dataout=0, dataout_valid=0, dataout_error=0, ps2_clk_out=1, ps2_dat_out=1; state IDLE; all counters 0; filtered lines 1.
- Synchronisation and filtering:
  - Each input passes a 2-FF synchroniser.
  - It then passes a deglitch filter. The filtered output changes only after the synchronised level differs from it for FILTER_CYCLES = max(2, CLK_FREQ*FILTER_NS/1e9) consecutive clocks.
  - Any return to the current level restarts the count.
- Edge detection: a PS/2 clock falling edge is filtered clk going 1→0. Data is sampled from filtered dat in the same cycle.
- Frame format: start(0), D0..D7 LSB first, odd parity, stop(1).
- States:
  - IDLE: on an edge with dat=0 → DATA, bit counter=0. An edge with dat=1 is ignored; no error.
  - DATA: shift dat in at bit[counter]. After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: on the edge, check ^{data,parity}==1 and stop==1.
    - Pass → dataout<=data and dataout_valid=1 in the next cycle.
    - Fail → dataout_error=1 in the next cycle; dataout keeps its old value.
    - Either way → IDLE.
- Latency: valid/error is asserted 1 clk after the stop-bit edge is detected, which is 2 + FILTER_CYCLES + 1 clocks after the raw pin edge.
- Strobes: valid and error are mutually exclusive and never assert on consecutive cycles from the same frame.
- Timeout:
  - Outside IDLE, a counter runs from 0 and resets on every falling edge.
  - On reaching TIMEOUT_CYCLES = CLK_FREQ/1e6*TIMEOUT_US: dataout_error pulses for one cycle, state → IDLE, partial data is discarded.
  - The counter is sized with $clog2 and must not wrap; it saturates and is cleared in IDLE.
- Simultaneous events: a falling edge in the same cycle the timeout is reached is accepted as an edge, not a timeout.
- Reset mid-frame: partial frame discarded; the next start bit after reset release is received normally. Back-to-back frames need no idle gap beyond the stop bit.

Optional Feature:
- Macro: PS2_RX_INHIBIT_EN.
- Defined:
  - After any dataout_error, ps2_clk_out is driven 0 for INHIBIT_CYCLES = CLK_FREQ/1e6*INHIBIT_US, then released. This forces the device to abort and retransmit.
  - The receiver stays in IDLE and ignores edges while inhibiting, plus FILTER_CYCLES after release.
  - ps2_dat_out stays 1.
- Not defined: ps2_clk_out and ps2_dat_out are constant 1, and no inhibit logic is present.

Decomposition:
- Package ps2_rx_pkg:
  - State enum {IDLE, DATA, PARITY, STOP}.
  - FRAME_DATA_BITS=8.
  - Functions computing FILTER_CYCLES, TIMEOUT_CYCLES and INHIBIT_CYCLES from parameters.
- Sub-module ps2_line_filter (synchroniser + deglitch counter, parameter CYCLES, reset output 1).
  - Instantiated twice, for clk and for dat, so both lines see equal latency.

Test Plan:
- Setup: CLK_FREQ=28e6; PS/2 bit period 60 µs; data driven at mid-high of the PS/2 clock.
- Good frame: frame 0x1C, parity 0 → exactly one dataout_valid pulse; dataout=0x1C; no error.
- Bad parity: frame 0x1C with parity 1 → one dataout_error pulse; dataout keeps its previous value (0x00 after reset); no valid.
- Bad stop: frame 0x5A with stop bit 0 → error pulse. A following good frame 0xF0 gives valid with dataout=0xF0.
- Timeout:
  - Stimulus: send start + 4 data bits, then hold the clock high 1.5 ms.
  - Required: error pulse 1.000 ms ±1 clk after the last edge.
  - Then good frame 0xE0 → valid, dataout=0xE0.
- Glitch rejection: 200 ns low pulses on ps2_clk_in in idle and mid-frame → no state change; the surrounding frame 0x29 is still received correctly.
- Reset mid-frame: assert rst_n low after 5 bits → all outputs return to reset values. After release, frame 0x76 → valid, dataout=0x76.
- With PS2_RX_INHIBIT_EN: bad parity → ps2_clk_out low for 2800 clks, then high. Edges during inhibit produce no strobes.
